apb_master_bridge: RTL

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// Purpose : single-outstanding command-to-APB master bridge with wait-state timeout.
// Latency : 3 PCLK cycles from acceptance to rsp_valid with zero wait states; back-to-back every 2 cycles.
// Backpressure: cmd_ready is low while a transfer is in SETUP or waiting in ACCESS; rsp_* cannot be stalled.
//
// Ports:
//   PCLK, PRESET                  clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata   command request handshake
//   rsp_valid/rdata/err/timeout        one-cycle completion pulse and status
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB request (all registered)
//   PRDATA/PREADY/PSLVERR              APB slave response
module apb_master_bridge #(
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [DATAWIDTH-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0] PWDATA,
  input  logic [DATAWIDTH-1:0] PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       timed_out;
  logic       accept;

  // Once the wait count hits TIMEOUT the current ACCESS cycle is the abort
  // cycle: a PREADY arriving now is ignored and no new command is taken.
  assign timed_out = (wait_cnt == TMO);

  always_comb begin
    cmd_ready = 1'b0;
    if (!PRESET) begin
      case (state)
        IDLE:    cmd_ready = 1'b1;
        ACCESS:  cmd_ready = PREADY && !timed_out;
        default: cmd_ready = 1'b0;
      endcase
    end
  end

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= 8'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            PWRITE  <= cmd_write;
            PADDR   <= cmd_addr;
            PWDATA  <= cmd_wdata;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end

        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= 8'd0;
          state    <= ACCESS;
        end

        ACCESS: begin
          if (timed_out) begin
            // Abort: rsp_rdata deliberately left untouched.
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= IDLE;
          end else if (PREADY) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            if (!PWRITE) begin
              rsp_rdata <= PRDATA;
            end
            PENABLE <= 1'b0;
            if (accept) begin
              // Back-to-back: next transfer goes straight to SETUP.
              PWRITE <= cmd_write;
              PADDR  <= cmd_addr;
              PWDATA <= cmd_wdata;
              state  <= SETUP;
            end else begin
              PSEL  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
